// File: rtl/alu_issue_queue_pkg.sv
// Shared constants, slot layout and CDB snoop helper for the ALU issue queue.
package alu_issue_queue_pkg;

    localparam int ROB_W           = 4;
    localparam int ENTRIES_DEFAULT = 8;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // One reservation slot: decode fields plus two tagged operands.
    typedef struct packed {
        logic             busy;
        logic [6:0]       opcode;
        logic [2:0]       precise;
        logic             more_precise;
        logic [31:0]      pc;
        logic [31:0]      imm;
        logic [ROB_W-1:0] rob_entry;
        logic             qj_busy;
        logic [ROB_W-1:0] qj;
        logic [31:0]      vj;
        logic             qk_busy;
        logic [ROB_W-1:0] qk;
        logic [31:0]      vk;
    } rs_slot_t;

    // Operand state after snooping the result buses.
    typedef struct packed {
        logic        busy;
        logic [31:0] val;
    } operand_t;

    // Resolve a waiting operand against both result buses; the ALU bus has priority.
    function automatic operand_t snoop(
        input logic             busy,
        input logic [ROB_W-1:0] tag,
        input logic [31:0]      val,
        input logic             alu_valid,
        input logic [ROB_W-1:0] alu_tag,
        input logic [31:0]      alu_val,
        input logic             lsb_valid,
        input logic [ROB_W-1:0] lsb_tag,
        input logic [31:0]      lsb_val
    );
        operand_t res;
        res.busy = busy;
        res.val  = val;
        if (busy) begin
            if (alu_valid && (alu_tag == tag)) begin
                res.busy = 1'b0;
                res.val  = alu_val;
            end else if (lsb_valid && (lsb_tag == tag)) begin
                res.busy = 1'b0;
                res.val  = lsb_val;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_issue_queue_prio_enc.sv
// Lowest-index priority encoder used for both free-slot and ready-slot picking.
module rs_prio_enc #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]         req,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     found
);

    localparam int IDX_W = $clog2(WIDTH);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// ALU reservation station: holds dispatched ops until both operands are known,
// snoops the ALU and LSB result buses, and issues one ready op per cycle.
module alu_issue_queue
    import alu_issue_queue_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             rollback_config,
    input  logic             in_config,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_precise,
    input  logic             in_more_precise,
    input  logic [31:0]      in_PC,
    input  logic [31:0]      in_imm,
    input  logic [ROB_W-1:0] in_rob_entry,
    input  logic             in_qj_busy,
    input  logic             in_qk_busy,
    input  logic [ROB_W-1:0] in_qj,
    input  logic [ROB_W-1:0] in_qk,
    input  logic [31:0]      in_vj,
    input  logic [31:0]      in_vk,
    input  logic             cdb_alu_config,
    input  logic             cdb_lsb_config,
    input  logic [ROB_W-1:0] cdb_alu_rob_entry,
    input  logic [ROB_W-1:0] cdb_lsb_rob_entry,
    input  logic [31:0]      cdb_alu_val,
    input  logic [31:0]      cdb_lsb_val,
    output logic             out_full,
    output logic             out_config,
    output logic [31:0]      out_a,
    output logic [31:0]      out_b,
    output logic [31:0]      out_PC,
    output logic [31:0]      out_imm,
    output logic [6:0]       out_opcode,
    output logic [2:0]       out_precise,
    output logic             out_more_precise,
    output logic [ROB_W-1:0] out_rob_entry
);

    localparam int IDX_W = $clog2(ENTRIES);

    rs_slot_t slots      [ENTRIES];
    rs_slot_t slots_next [ENTRIES];
    rs_slot_t dispatch_slot;

    logic [ENTRIES-1:0] busy_vec;
    logic [ENTRIES-1:0] ready_vec;
    logic [ENTRIES-1:0] busy_next;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   ready_idx;
    logic               free_found;
    logic               ready_found;
    logic               dispatch_en;
    logic               issue_en;

    // Occupancy and readiness come from registered state only, so a slot
    // written or woken at this edge cannot issue until the following one.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            busy_vec[i]  = slots[i].busy;
            ready_vec[i] = slots[i].busy & ~slots[i].qj_busy & ~slots[i].qk_busy;
        end
    end

    rs_prio_enc #(.WIDTH(ENTRIES)) u_free_enc (
        .req   (~busy_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_prio_enc #(.WIDTH(ENTRIES)) u_ready_enc (
        .req   (ready_vec),
        .idx   (ready_idx),
        .found (ready_found)
    );

    assign dispatch_en = in_config & ~out_full & free_found;
    assign issue_en    = ready_found;

    // Build the incoming slot, forwarding any same-cycle broadcast into it.
    always_comb begin
        dispatch_slot              = '0;
        dispatch_slot.busy         = 1'b1;
        dispatch_slot.opcode       = in_opcode;
        dispatch_slot.precise      = in_precise;
        dispatch_slot.more_precise = in_more_precise;
        dispatch_slot.pc           = in_PC;
        dispatch_slot.imm          = in_imm;
        dispatch_slot.rob_entry    = in_rob_entry;
        dispatch_slot.qj           = in_qj;
        dispatch_slot.qk           = in_qk;
        {dispatch_slot.qj_busy, dispatch_slot.vj} =
            snoop(in_qj_busy, in_qj, in_vj,
                  cdb_alu_config, cdb_alu_rob_entry, cdb_alu_val,
                  cdb_lsb_config, cdb_lsb_rob_entry, cdb_lsb_val);
        {dispatch_slot.qk_busy, dispatch_slot.vk} =
            snoop(in_qk_busy, in_qk, in_vk,
                  cdb_alu_config, cdb_alu_rob_entry, cdb_alu_val,
                  cdb_lsb_config, cdb_lsb_rob_entry, cdb_lsb_val);
    end

    // Next slot contents: wakeup, then issue frees a slot, then dispatch fills
    // one; a rollback discards every slot regardless of the rest.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            slots_next[i] = slots[i];
            {slots_next[i].qj_busy, slots_next[i].vj} =
                snoop(slots[i].qj_busy, slots[i].qj, slots[i].vj,
                      cdb_alu_config, cdb_alu_rob_entry, cdb_alu_val,
                      cdb_lsb_config, cdb_lsb_rob_entry, cdb_lsb_val);
            {slots_next[i].qk_busy, slots_next[i].vk} =
                snoop(slots[i].qk_busy, slots[i].qk, slots[i].vk,
                      cdb_alu_config, cdb_alu_rob_entry, cdb_alu_val,
                      cdb_lsb_config, cdb_lsb_rob_entry, cdb_lsb_val);
        end
        if (issue_en) begin
            slots_next[ready_idx].busy = 1'b0;
        end
        if (dispatch_en) begin
            slots_next[free_idx] = dispatch_slot;
        end
        if (rollback_config) begin
            for (int i = 0; i < ENTRIES; i++) begin
                slots_next[i].busy = 1'b0;
            end
        end
    end

    // Post-edge occupancy, used to register the full flag.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            busy_next[i] = slots_next[i].busy;
        end
    end

    // Slot storage; rdy low freezes everything and drops bus traffic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                slots[i] <= '0;
            end
        end else if (rdy) begin
            for (int i = 0; i < ENTRIES; i++) begin
                slots[i] <= slots_next[i];
            end
        end
    end

    // Issue register: pulses out_config for one cycle, other fields hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_full         <= 1'b0;
            out_config       <= 1'b0;
            out_a            <= '0;
            out_b            <= '0;
            out_PC           <= '0;
            out_imm          <= '0;
            out_opcode       <= '0;
            out_precise      <= '0;
            out_more_precise <= 1'b0;
            out_rob_entry    <= '0;
        end else if (rdy) begin
            out_full <= &busy_next;
            if (rollback_config) begin
                out_config <= 1'b0;
            end else if (issue_en) begin
                out_config       <= 1'b1;
                out_a            <= slots[ready_idx].vj;
                out_b            <= slots[ready_idx].vk;
                out_PC           <= slots[ready_idx].pc;
                out_imm          <= slots[ready_idx].imm;
                out_opcode       <= slots[ready_idx].opcode;
                out_precise      <= slots[ready_idx].precise;
                out_more_precise <= slots[ready_idx].more_precise;
                out_rob_entry    <= slots[ready_idx].rob_entry;
            end else begin
                out_config <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed scenarios followed by
// random traffic, compared every cycle against a slot-list reference model.
module tb_alu_issue_queue;
    import alu_issue_queue_pkg::*;

    localparam int N = 8;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        rollback_config;
    logic        in_config;
    logic [6:0]  in_opcode;
    logic [2:0]  in_precise;
    logic        in_more_precise;
    logic [31:0] in_PC;
    logic [31:0] in_imm;
    logic [3:0]  in_rob_entry;
    logic        in_qj_busy;
    logic        in_qk_busy;
    logic [3:0]  in_qj;
    logic [3:0]  in_qk;
    logic [31:0] in_vj;
    logic [31:0] in_vk;
    logic        cdb_alu_config;
    logic        cdb_lsb_config;
    logic [3:0]  cdb_alu_rob_entry;
    logic [3:0]  cdb_lsb_rob_entry;
    logic [31:0] cdb_alu_val;
    logic [31:0] cdb_lsb_val;
    logic        out_full;
    logic        out_config;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [31:0] out_PC;
    logic [31:0] out_imm;
    logic [6:0]  out_opcode;
    logic [2:0]  out_precise;
    logic        out_more_precise;
    logic [3:0]  out_rob_entry;

    int total = 0;
    int bad   = 0;

    // Reference model: a list of occupied slots with known/unknown operands.
    bit          m_valid [N];
    logic [6:0]  m_opc   [N];
    logic [2:0]  m_f3    [N];
    logic        m_f7    [N];
    logic [31:0] m_pc    [N];
    logic [31:0] m_imm   [N];
    logic [3:0]  m_rob   [N];
    bit          m_aok   [N];
    logic [31:0] m_a     [N];
    logic [3:0]  m_atag  [N];
    bit          m_bok   [N];
    logic [31:0] m_b     [N];
    logic [3:0]  m_btag  [N];

    logic        e_config, e_full, e_f7;
    logic [31:0] e_a, e_b, e_pc, e_imm;
    logic [6:0]  e_opc;
    logic [2:0]  e_f3;
    logic [3:0]  e_rob;

    alu_issue_queue #(.ENTRIES(N)) dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .rollback_config   (rollback_config),
        .in_config         (in_config),
        .in_opcode         (in_opcode),
        .in_precise        (in_precise),
        .in_more_precise   (in_more_precise),
        .in_PC             (in_PC),
        .in_imm            (in_imm),
        .in_rob_entry      (in_rob_entry),
        .in_qj_busy        (in_qj_busy),
        .in_qk_busy        (in_qk_busy),
        .in_qj             (in_qj),
        .in_qk             (in_qk),
        .in_vj             (in_vj),
        .in_vk             (in_vk),
        .cdb_alu_config    (cdb_alu_config),
        .cdb_lsb_config    (cdb_lsb_config),
        .cdb_alu_rob_entry (cdb_alu_rob_entry),
        .cdb_lsb_rob_entry (cdb_lsb_rob_entry),
        .cdb_alu_val       (cdb_alu_val),
        .cdb_lsb_val       (cdb_lsb_val),
        .out_full          (out_full),
        .out_config        (out_config),
        .out_a             (out_a),
        .out_b             (out_b),
        .out_PC            (out_PC),
        .out_imm           (out_imm),
        .out_opcode        (out_opcode),
        .out_precise       (out_precise),
        .out_more_precise  (out_more_precise),
        .out_rob_entry     (out_rob_entry)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void modelReset();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        e_config = 1'b0; e_full = 1'b0; e_a = '0; e_b = '0; e_pc = '0; e_imm = '0;
        e_opc = '0; e_f3 = '0; e_f7 = 1'b0; e_rob = '0;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    function automatic void modelStep();
        int iss = -1;
        int fr = -1;
        int cnt = 0;
        bit was_full;
        if (!rdy) return;
        if (rollback_config) begin
            for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
            e_config = 1'b0;
            e_full   = 1'b0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (m_valid[i] && m_aok[i] && m_bok[i] && iss < 0) iss = i;
            if (!m_valid[i] && fr < 0) fr = i;
            if (m_valid[i]) cnt++;
        end
        was_full = (cnt == N);
        for (int i = 0; i < N; i++) begin
            if (m_valid[i] && !m_aok[i]) begin
                if (cdb_alu_config && cdb_alu_rob_entry == m_atag[i]) begin
                    m_aok[i] = 1'b1; m_a[i] = cdb_alu_val;
                end else if (cdb_lsb_config && cdb_lsb_rob_entry == m_atag[i]) begin
                    m_aok[i] = 1'b1; m_a[i] = cdb_lsb_val;
                end
            end
            if (m_valid[i] && !m_bok[i]) begin
                if (cdb_alu_config && cdb_alu_rob_entry == m_btag[i]) begin
                    m_bok[i] = 1'b1; m_b[i] = cdb_alu_val;
                end else if (cdb_lsb_config && cdb_lsb_rob_entry == m_btag[i]) begin
                    m_bok[i] = 1'b1; m_b[i] = cdb_lsb_val;
                end
            end
        end
        if (iss >= 0) begin
            e_config = 1'b1;
            e_a = m_a[iss]; e_b = m_b[iss]; e_pc = m_pc[iss]; e_imm = m_imm[iss];
            e_opc = m_opc[iss]; e_f3 = m_f3[iss]; e_f7 = m_f7[iss]; e_rob = m_rob[iss];
            m_valid[iss] = 1'b0;
        end else begin
            e_config = 1'b0;
        end
        if (in_config && !was_full) begin
            m_valid[fr] = 1'b1;
            m_opc[fr] = in_opcode; m_f3[fr] = in_precise; m_f7[fr] = in_more_precise;
            m_pc[fr] = in_PC; m_imm[fr] = in_imm; m_rob[fr] = in_rob_entry;
            m_atag[fr] = in_qj; m_btag[fr] = in_qk;
            m_aok[fr] = !in_qj_busy; m_a[fr] = in_vj;
            m_bok[fr] = !in_qk_busy; m_b[fr] = in_vk;
            if (in_qj_busy && cdb_alu_config && cdb_alu_rob_entry == in_qj) begin
                m_aok[fr] = 1'b1; m_a[fr] = cdb_alu_val;
            end else if (in_qj_busy && cdb_lsb_config && cdb_lsb_rob_entry == in_qj) begin
                m_aok[fr] = 1'b1; m_a[fr] = cdb_lsb_val;
            end
            if (in_qk_busy && cdb_alu_config && cdb_alu_rob_entry == in_qk) begin
                m_bok[fr] = 1'b1; m_b[fr] = cdb_alu_val;
            end else if (in_qk_busy && cdb_lsb_config && cdb_lsb_rob_entry == in_qk) begin
                m_bok[fr] = 1'b1; m_b[fr] = cdb_lsb_val;
            end
        end
        cnt = 0;
        for (int i = 0; i < N; i++) if (m_valid[i]) cnt++;
        e_full = (cnt == N);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        check("out_config", 32'(out_config), 32'(e_config));
        check("out_full", 32'(out_full), 32'(e_full));
        check("out_a", out_a, e_a);
        check("out_b", out_b, e_b);
        check("out_PC", out_PC, e_pc);
        check("out_imm", out_imm, e_imm);
        check("out_opcode", 32'(out_opcode), 32'(e_opc));
        check("out_precise", 32'(out_precise), 32'(e_f3));
        check("out_more_precise", 32'(out_more_precise), 32'(e_f7));
        check("out_rob_entry", 32'(out_rob_entry), 32'(e_rob));
    endtask

    task automatic clearInputs();
        rdy = 1'b1; rollback_config = 1'b0; in_config = 1'b0;
        in_opcode = '0; in_precise = '0; in_more_precise = 1'b0; in_PC = '0; in_imm = '0;
        in_rob_entry = '0; in_qj_busy = 1'b0; in_qk_busy = 1'b0; in_qj = '0; in_qk = '0;
        in_vj = '0; in_vk = '0;
        cdb_alu_config = 1'b0; cdb_lsb_config = 1'b0; cdb_alu_rob_entry = '0;
        cdb_lsb_rob_entry = '0; cdb_alu_val = '0; cdb_lsb_val = '0;
    endtask

    task automatic setDispatch(input logic [3:0] rob, input logic qjb, input logic [3:0] qj,
                               input logic [31:0] vj, input logic qkb, input logic [3:0] qk,
                               input logic [31:0] vk);
        in_config = 1'b1; in_opcode = OPC_OP; in_precise = 3'd0; in_more_precise = 1'b0;
        in_PC = 32'h1000 + {26'd0, rob, 2'b00}; in_imm = 32'h0;
        in_rob_entry = rob; in_qj_busy = qjb; in_qj = qj; in_vj = vj;
        in_qk_busy = qkb; in_qk = qk; in_vk = vk;
    endtask

    // One clock edge: model update, check #1 after the edge, then clear inputs.
    task automatic applyStimulus();
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
        @(negedge clk);
        clearInputs();
    endtask

    initial begin
        clearInputs();
        rst = 1'b1;
        modelReset();
        #3;
        checkOutput();
        @(negedge clk);
        rst = 1'b0;

        // ADD with both operands ready.
        setDispatch(4'd1, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7);
        applyStimulus();
        check("add_not_same_edge", 32'(out_config), 32'd0);
        applyStimulus();
        check("add_issue", 32'(out_config), 32'd1);
        check("add_a", out_a, 32'd5);
        check("add_b", out_b, 32'd7);
        check("add_rob", 32'(out_rob_entry), 32'd1);
        applyStimulus();
        check("add_pulse_end", 32'(out_config), 32'd0);

        // rs1 waiting on tag 3, woken by the ALU bus two cycles later.
        setDispatch(4'd2, 1'b1, 4'd3, 32'h0, 1'b0, 4'd0, 32'd2);
        applyStimulus();
        applyStimulus();
        cdb_alu_config = 1'b1; cdb_alu_rob_entry = 4'd3; cdb_alu_val = 32'h10;
        applyStimulus();
        check("wake_no_same_edge", 32'(out_config), 32'd0);
        applyStimulus();
        check("wake_issue", 32'(out_config), 32'd1);
        check("wake_a", out_a, 32'h10);

        // rs2 forwarded from the LSB bus in the dispatch cycle.
        setDispatch(4'd4, 1'b0, 4'd0, 32'd9, 1'b1, 4'd6, 32'h0);
        cdb_lsb_config = 1'b1; cdb_lsb_rob_entry = 4'd6; cdb_lsb_val = 32'hABCD;
        applyStimulus();
        applyStimulus();
        check("fwd_issue", 32'(out_config), 32'd1);
        check("fwd_b", out_b, 32'hABCD);

        // Fill all slots with blocked ops, then try a ninth.
        for (int i = 0; i < N; i++) begin
            setDispatch(4'(i), 1'b1, 4'(i + 8), 32'h0, 1'b0, 4'd0, 32'(i));
            applyStimulus();
        end
        check("full_set", 32'(out_full), 32'd1);
        setDispatch(4'd9, 1'b1, 4'd1, 32'h0, 1'b0, 4'd0, 32'h99);
        applyStimulus();
        check("full_drop", 32'(out_full), 32'd1);
        cdb_alu_config = 1'b1; cdb_alu_rob_entry = 4'd10; cdb_alu_val = 32'h22;
        applyStimulus();
        applyStimulus();
        check("full_issue", 32'(out_config), 32'd1);
        check("full_issue_rob", 32'(out_rob_entry), 32'd2);
        check("full_issue_a", out_a, 32'h22);
        check("full_clear", 32'(out_full), 32'd0);

        // Drain slots 0 and 1 so five remain, then roll back.
        cdb_alu_config = 1'b1; cdb_alu_rob_entry = 4'd8; cdb_alu_val = 32'h80;
        cdb_lsb_config = 1'b1; cdb_lsb_rob_entry = 4'd9; cdb_lsb_val = 32'h90;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        check("pre_rollback_issue", 32'(out_rob_entry), 32'd1);
        rollback_config = 1'b1;
        applyStimulus();
        check("rollback_config", 32'(out_config), 32'd0);
        check("rollback_full", 32'(out_full), 32'd0);
        cdb_alu_config = 1'b1; cdb_alu_rob_entry = 4'd11; cdb_alu_val = 32'hB0;
        applyStimulus();
        applyStimulus();
        check("rollback_no_issue", 32'(out_config), 32'd0);

        // Asynchronous reset while an issue pulse is on the outputs.
        setDispatch(4'd5, 1'b0, 4'd0, 32'h55, 1'b0, 4'd0, 32'h66);
        applyStimulus();
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
        check("pre_reset_issue", 32'(out_config), 32'd1);
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput();
        check("async_reset_config", 32'(out_config), 32'd0);
        check("async_reset_a", out_a, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clearInputs();
        setDispatch(4'd7, 1'b0, 4'd0, 32'h77, 1'b0, 4'd0, 32'h78);
        applyStimulus();
        applyStimulus();
        check("post_reset_issue", 32'(out_config), 32'd1);
        check("post_reset_rob", 32'(out_rob_entry), 32'd7);

        // Random traffic including stalls, rollbacks and bus collisions.
        for (int c = 0; c < 400; c++) begin
            rdy             = ($urandom_range(0, 9) != 0);
            rollback_config = ($urandom_range(0, 39) == 0);
            in_config       = ($urandom_range(0, 9) < 6);
            in_opcode       = 7'($urandom);
            in_precise      = 3'($urandom);
            in_more_precise = 1'($urandom);
            in_PC           = $urandom;
            in_imm          = $urandom;
            in_rob_entry    = 4'($urandom);
            in_qj_busy      = 1'($urandom);
            in_qk_busy      = 1'($urandom);
            in_qj           = 4'($urandom);
            in_qk           = 4'($urandom);
            in_vj           = $urandom;
            in_vk           = $urandom;
            cdb_alu_config    = ($urandom_range(0, 9) < 4);
            cdb_lsb_config    = ($urandom_range(0, 9) < 4);
            cdb_alu_rob_entry = 4'($urandom);
            cdb_lsb_rob_entry = 4'($urandom);
            cdb_alu_val       = $urandom;
            cdb_lsb_val       = $urandom;
            applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
